// File: rtl/vme_system_arbiter_if.sv
// Arbiter-side VME arbitration signals: request/busy inputs, grant/clear outputs and status.
// master = arbiter, slave = bus/backplane side.
interface vme_system_arbiter_if;
  logic       arb_enable;
  logic [3:0] vme_br;
  logic       vme_bbsy;
  logic [3:0] vme_bg_out;
  logic       vme_bclr;
  logic [1:0] owner_level;
  logic       bus_busy;
  logic       grant_timeout;

  modport master (
    input  arb_enable, vme_br, vme_bbsy,
    output vme_bg_out, vme_bclr, owner_level, bus_busy, grant_timeout
  );

  modport slave (
    output arb_enable, vme_br, vme_bbsy,
    input  vme_bg_out, vme_bclr, owner_level, bus_busy, grant_timeout
  );
endinterface

// File: rtl/vme_system_arbiter.sv
// VME slot-1 bus arbiter (PRI or RRS) driving BGxOUT* and BCLR* from synchronized BR*/BBSY*.
// Latency: BR* low to BG* low in SYNC_STAGES+1 clocks; all outputs registered.
// Backpressure: none; grants wait for BBSY* idle, SETTLE time and arb_enable.
module vme_system_arbiter #(
  parameter int ROUND_ROBIN   = 0,
  parameter int SYNC_STAGES   = 2,
  parameter int GRANT_TIMEOUT = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input logic                   clock,
  input logic                   reset,
  vme_system_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, SETTLE} state_t;

  state_t     state_q, state_d;
  logic [3:0] bg_q, bg_d;
  logic       bclr_q, bclr_d;
  logic [1:0] owner_q, owner_d;
  logic       busy_q, busy_d;
  logic       to_q, to_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] tmr_q, tmr_d;
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] sync_d [SYNC_STAGES];

  logic [3:0] br_act;
  logic       bbsy_act;
  logic [1:0] sel;
  logic [1:0] idx;
  logic       preempt;

  always_comb begin
    sync_d[0] = {bus.vme_bbsy, bus.vme_br};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign br_act   = ~sync_q[SYNC_STAGES-1][3:0];
  assign bbsy_act = ~sync_q[SYNC_STAGES-1][4];

  // RRS scans pointer-4 first so that pointer-1 (scanned last) has the final say.
  always_comb begin
    sel = 2'd0;
    idx = 2'd0;
    if (ROUND_ROBIN != 0) begin
      for (int k = 4; k >= 1; k--) begin
        idx = ptr_q - 2'(k);
        if (br_act[idx]) sel = idx;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (br_act[i]) sel = 2'(i);
      end
    end
  end

  always_comb begin
    if (ROUND_ROBIN != 0) preempt = |(br_act & ~(4'b0001 << owner_q));
    else                  preempt = |(br_act & (4'b1110 << owner_q));
  end

  always_comb begin
    state_d = state_q;
    bg_d    = bg_q;
    bclr_d  = bclr_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    to_d    = 1'b0;
    ptr_d   = ptr_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        if (bus.arb_enable && (|br_act) && !bbsy_act) begin
          bg_d      = 4'b1111;
          bg_d[sel] = 1'b0;
          owner_d   = sel;
          tmr_d     = GRANT_TIMEOUT[7:0];
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (bbsy_act) begin
          bg_d    = 4'b1111;
          busy_d  = 1'b1;
          ptr_d   = owner_q;
          state_d = BUSY;
        end else if (tmr_q == 8'd1) begin
          bg_d    = 4'b1111;
          to_d    = 1'b1;
          tmr_d   = SETTLE_CYCLES[7:0];
          state_d = SETTLE;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      BUSY: begin
        if (!bbsy_act) begin
          bclr_d  = 1'b1;
          busy_d  = 1'b0;
          tmr_d   = SETTLE_CYCLES[7:0];
          state_d = SETTLE;
        end else if (preempt) begin
          bclr_d = 1'b0;
        end
      end
      SETTLE: begin
        if (tmr_q <= 8'd1) begin
          tmr_d   = 8'd0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      bg_q    <= 4'b1111;
      bclr_q  <= 1'b1;
      owner_q <= 2'd0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      ptr_q   <= 2'd0;
      tmr_q   <= 8'd0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 5'h1f;
    end else begin
      state_q <= state_d;
      bg_q    <= bg_d;
      bclr_q  <= bclr_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      ptr_q   <= ptr_d;
      tmr_q   <= tmr_d;
      sync_q  <= sync_d;
    end
  end

  assign bus.vme_bg_out    = bg_q;
  assign bus.vme_bclr      = bclr_q;
  assign bus.owner_level   = owner_q;
  assign bus.bus_busy      = busy_q;
  assign bus.grant_timeout = to_q;

endmodule

// File: doc/vme_system_arbiter.md
Name: vme_system_arbiter

Overview:
- VME slot-1 system-controller bus arbiter.
- Samples the four bus-request lines (BR0*-BR3*) and BBSY*, and drives one of the four daisy-chain grant lines (BG0OUT*-BG3OUT*).
- Asserts BCLR* to ask the current owner to release the bus early.
- Supports priority (PRI) and round-robin (RRS) selection.
- Works alongside vme_bus_arbitration, which is the requester side on each board.

Parameters:
- ROUND_ROBIN, 0: 0 = PRI (level 3 highest), 1 = RRS.
- SYNC_STAGES, 2: flop depth of the input synchronizer on vme_br and vme_bbsy; legal values 2 or 3.
- GRANT_TIMEOUT, 64: cycles a grant is held without BBSY* before the grant is withdrawn; legal range 2..255.
- SETTLE_CYCLES, 4: idle cycles after BBSY* release before the next grant; legal range 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- arb_enable  in  1  1 = arbitrate; 0 = no new grants (an ongoing tenure completes)
- vme_br  in  4  bus request levels 3..0, active low, asynchronous
- vme_bbsy  in  1  bus busy, active low, asynchronous
- vme_bg_out  out  4  grant out levels 3..0, active low, registered
- vme_bclr  out  1  bus clear, active low, registered
- owner_level  out  2  level of the last or current grant
- bus_busy  out  1  high while in the BUSY state
- grant_timeout  out  1  one-cycle pulse when a grant times out

Behaviour:
- ACTIVE = 0 on all vme_* lines.
- vme_br and vme_bbsy pass through SYNC_STAGES flops; all decisions use the synchronized values.
- Reset (synchronous, honoured in any state, including mid-grant or mid-tenure):
  - state = IDLE, vme_bg_out = 4'b1111, vme_bclr = 1
  - owner_level = 0, bus_busy = 0, grant_timeout = 0
  - RR pointer = 0, timers = 0, synchronizer flops = all 1
- States: IDLE, GRANT, BUSY, SETTLE.
- IDLE:
  - Condition to grant: arb_enable = 1, any synchronized BR active, and synchronized BBSY inactive.
  - On that condition: select a level, drive its vme_bg_out bit active (only that one bit), set owner_level, load the timer with GRANT_TIMEOUT, go to GRANT.
  - Latency: BR stable low → BG active on rising edge SYNC_STAGES+1.
- Level selection:
  - PRI: highest active level wins.
  - RRS: search order is pointer-1, pointer-2, … modulo 4. With pointer = 0 after reset, the order is 3, 2, 1, 0.
  - RRS: the pointer updates to the granted level when BUSY is entered (not on grant).
- GRANT:
  - Synchronized BBSY active → release BG (all 1), bus_busy = 1, go to BUSY.
  - Otherwise the timer decrements each cycle. When it is 1 and BBSY is still inactive: BG released, grant_timeout pulses for 1 cycle, go to SETTLE.
  - BG is therefore held exactly GRANT_TIMEOUT cycles on timeout.
  - A BR that drops during GRANT is ignored; the grant runs to BBSY or timeout.
  - If BBSY and timeout coincide, BBSY wins (go to BUSY, no pulse).
- BUSY:
  - PRI only: vme_bclr goes active the cycle after any synchronized BR at a level above owner_level is active. It stays active until BBSY releases, even if that request drops.
  - RRS: vme_bclr goes active when any BR other than owner_level is active.
  - Synchronized BBSY inactive → vme_bclr = 1, bus_busy = 0, load the settle counter with SETTLE_CYCLES, go to SETTLE.
- SETTLE:
  - Counter decrements; at 1, go to IDLE.
  - Requests are not evaluated during SETTLE.
- Glitch rule: BBSY observed active while in IDLE (a foreign arbiter or stale owner) blocks granting until it goes inactive; no error is flagged.
- Invariant: never more than one vme_bg_out bit active in any cycle.
- owner_level holds its value after the tenure ends.

Test Plan:
- Single request: BR2 low, BBSY high → BG2 = 0 on edge 3. Raise BBSY active 5 cycles later → BG back to 1111 within SYNC_STAGES+1 edges, bus_busy = 1, owner_level = 2.
- PRI contention: BR1 and BR3 low together → BG3 granted first. After BBSY cycle and SETTLE_CYCLES = 4 idle cycles, BR1 is granted.
- Preemption: owner level 0 in BUSY, BR3 goes low → vme_bclr = 0 after sync latency+1. Release BBSY → vme_bclr = 1, then BG3 is granted after SETTLE.
- RRS rotation with ROUND_ROBIN = 1: all BR low, each tenure completes → grant order is 3, 2, 1, 0, 3.
- Timeout with GRANT_TIMEOUT = 8: BR0 low, BBSY never asserts → BG0 = 0 for exactly 8 cycles, then grant_timeout = 1 for 1 cycle and BG0 = 1.
- Reset mid-GRANT: reset high while BG1 = 0 → next edge BG = 1111, state IDLE, RR pointer 0.
- arb_enable = 0 with BR active → no BG for 20 cycles. Set arb_enable = 1 → grant follows next cycle.
